// File: rtl/core_dmem.sv
// Purpose: single-port byte-maskable data memory, one request per cycle, in-order read responses.
// Latency: reads respond 1 cycle after acceptance (2 with CORE_DMEM_OUTREG_EN); writes are posted.
// Backpressure: req_ready drops only when a stalled response leaves no room for another read.
// Config macro: CORE_DMEM_OUTREG_EN adds a second register stage after the array read.
module core_dmem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    // Storage is deliberately never reset so contents survive a reset pulse.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    // Output-stage registers, present in both builds.
    logic              o_vld;
    logic [DATA_W-1:0] o_dat;
    logic              o_err;

    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
    assign idx      = req_addr[IDX_W-1:0];
    // req_ready already carries !rst, so nothing is accepted during reset.
    assign wr_acc   = req_valid && req_ready && req_we && in_range;
    assign rd_acc   = req_valid && req_ready && !req_we;
    // Out-of-range reads return zero; the array is not touched for them.
    assign rd_word  = in_range ? mem[idx] : '0;

    // Byte-masked array write; out-of-range writes are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef CORE_DMEM_OUTREG_EN
    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;
    logic              s1_err;
    logic              s1_adv;

    // Stage 1 moves forward whenever the output slot is empty or being consumed.
    assign s1_adv    = s1_vld && (!o_vld || rsp_ready);
    // Only refuse when both slots are full and the head response is stalled.
    assign req_ready = !rst && !(s1_vld && o_vld && !rsp_ready);

    // Stage 1: capture array data at the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_err <= 1'b0;
        end else if (rd_acc) begin
            s1_vld <= 1'b1;
            s1_dat <= rd_word;
            s1_err <= !in_range;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // Output stage: refill from stage 1, otherwise empty once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            o_err <= 1'b0;
        end else if (s1_adv) begin
            o_vld <= 1'b1;
            o_dat <= s1_dat;
            o_err <= s1_err;
        end else if (rsp_ready) begin
            o_vld <= 1'b0;
        end
    end
`else
    // Single slot: a new read can only land if the current response leaves this edge.
    assign req_ready = !rst && !(o_vld && !rsp_ready);

    // Output stage: capture array data at the acceptance edge, empty once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            o_err <= 1'b0;
        end else if (rd_acc) begin
            o_vld <= 1'b1;
            o_dat <= rd_word;
            o_err <= !in_range;
        end else if (rsp_ready) begin
            o_vld <= 1'b0;
        end
    end
`endif

    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    assign rsp_valid = o_vld && !rst;
    assign rsp_rdata = rst ? '0 : o_dat;
    assign rsp_err   = o_err && !rst;

endmodule

// File: doc/core_dmem.md
CORE_DMEM -- requirements
Module: core_dmem

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256: number of words; need not be a power of two.
REQ-003 Parameter ADDR_W, default 8: word-address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready at posedge.
REQ-008 req_we  in  1  1=write, 0=read.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  out  1  read response present.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge.
REQ-014 rsp_rdata  out  DATA_W  read data.
REQ-015 rsp_err  out  1  response belongs to an out-of-range read.

Function
REQ-016 Storage SHALL be DEPTH x DATA_W words, with no reset of the contents.
REQ-017 An accepted write SHALL update only the bytes whose req_be bit is 1; all other bytes keep their value.
REQ-018 Writes SHALL be posted: no response is generated.
REQ-019 An accepted read SHALL produce exactly one response, and responses SHALL be delivered in acceptance order.
REQ-020 Read latency (acceptance edge to first rsp_valid=1) SHALL be 1 cycle without CORE_DMEM_OUTREG_EN and 2 cycles with it.
REQ-021 A read SHALL return the array contents at its acceptance edge; a write accepted on a later edge SHALL NOT alter that response.
REQ-022 A read accepted on the edge after a write to the same address SHALL return the newly written bytes.
REQ-023 req_be SHALL be ignored for reads: the full word is returned.
REQ-024 A request with req_addr >= DEPTH SHALL be handled as follows:
  - write: discarded, array unchanged;
  - read: rsp_rdata=0 and rsp_err=1.
REQ-025 For in-range reads, rsp_err SHALL be 0.
REQ-026 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_rdata and rsp_err SHALL hold stable.
REQ-027 req_ready SHALL be 0 exactly when accepting a read could overflow the response pipeline:
  - without the macro: rsp_valid && !rsp_ready;
  - with the macro: stage-1 slot full && rsp_valid && !rsp_ready.
REQ-028 Writes SHALL obey the same req_ready, so request order is preserved.
REQ-029 Back-to-back reads with rsp_ready=1 SHALL sustain one response per cycle.
REQ-030 A response consumed on the same edge a new read is accepted SHALL be replaced seamlessly, with no bubble.
REQ-031 When req_valid=0, no array update SHALL occur and the response pipeline SHALL only drain.

Reset
REQ-032 While rst=1:
  - rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0;
  - all pipeline valid flags are cleared.
REQ-033 Requests presented while rst=1 SHALL be ignored, and array contents SHALL be preserved.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight read responses; none SHALL appear after reset deasserts.
REQ-035 req_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-036 Macro CORE_DMEM_OUTREG_EN SHALL be the only configuration switch.
REQ-037 With CORE_DMEM_OUTREG_EN defined, a second register stage SHALL be added after the array read, with 2-cycle latency and throughput unchanged.
REQ-038 With CORE_DMEM_OUTREG_EN undefined, latency SHALL be 1 cycle and no extra stage is present.
REQ-039 REQ-016 through REQ-035 SHALL hold in both builds; only latency and the req_ready term differ.

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
  - Write addr 5 = 0xDEADBEEF, be=4'hF, then read addr 5: rsp_rdata=0xDEADBEEF, rsp_err=0 after 1 cycle (2 with the macro).
  - Write addr 5 = 0x11223344 with be=4'b0101, then read addr 5: rsp_rdata=0xDE22BE44.
  - DEPTH=200: write addr 250 = 0xFFFFFFFF, then read addr 250 gives rdata=0, err=1; read addr 200-255 mod check: addr 199 unchanged.
  - Reads to addrs 0..3 back-to-back, rsp_ready=0 for 3 cycles then 1: rsp_rdata stable while stalled, req_ready low per REQ-027, four responses in order with no loss or duplication.
  - Read addr 7 accepted, then write addr 7 = 0xA5A5A5A5 on the next edge: first response returns the old value; a following read of addr 7 returns 0xA5A5A5A5.
  - rst pulsed 1 cycle with two reads in flight: no rsp_valid afterwards, req_ready=1 the cycle after release, and previously written addr 5 still reads its last value.
